// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state and grant encodings for mem_port_arbiter
package arb_pkg;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_e;
  typedef enum logic {GRANT_I = 1'b0, GRANT_D = 1'b1} grant_e;
endpackage

// File: rtl/twomux.sv
// twomux: two-input mux, sel=0 -> a, sel=1 -> b
module twomux #(
  parameter int WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (I) and data (D), D first, I promoted after STARVE_LIMIT losses
// Ports: clk/rst (sync, active high); i_* instruction requester; d_* data requester;
// mem_* memory port; grant_sel registered grant (0 = I, 1 = D) steering the address mux.
// ARB_PERF_CNT_EN adds i_grant_cnt, d_grant_cnt, conflict_cnt.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_read,
  input  logic [WIDTH-1:0]   i_address,
  output logic [WIDTH-1:0]   i_rdata,
  output logic               i_resp,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [WIDTH-1:0]   d_address,
  input  logic [WIDTH-1:0]   d_wdata,
  input  logic [WIDTH/8-1:0] d_mbe,
  output logic [WIDTH-1:0]   d_rdata,
  output logic               d_resp,
  output logic               mem_read,
  output logic               mem_write,
  output logic [WIDTH-1:0]   mem_address,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic [WIDTH/8-1:0] mem_byte_enable,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_resp,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]        i_grant_cnt,
  output logic [31:0]        d_grant_cnt,
  output logic [31:0]        conflict_cnt,
`endif
  output logic               grant_sel
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  arb_state_e    r_state;
  grant_e        r_grant;
  logic [SW-1:0] r_starve;
  logic          w_i_req, w_d_req, w_idle, w_starved, w_go_i, w_go_d;
  assign w_i_req   = i_read;
  assign w_d_req   = d_read | d_write;
  assign w_idle    = r_state == IDLE;
  assign w_starved = r_starve == SW'(STARVE_LIMIT);
  // A grant happens either by arbitration in IDLE or by handing the port to the other pending requester on mem_resp.
  assign w_go_i = w_i_req & ((w_idle & (~w_d_req | w_starved)) | (r_state == SERVE_D & mem_resp));
  assign w_go_d = w_d_req & ((w_idle & ~(w_i_req & w_starved)) | (r_state == SERVE_I & mem_resp));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_grant  <= GRANT_I;
      r_starve <= '0;
    end else if (w_go_i) begin
      r_state  <= SERVE_I;
      r_grant  <= GRANT_I;
      r_starve <= '0;
    end else if (w_go_d) begin
      r_state <= SERVE_D;
      r_grant <= GRANT_D;
      if (w_idle & w_i_req & ~w_starved) r_starve <= r_starve + 1'b1;
    end else if (mem_resp & ~w_idle) begin
      r_state <= IDLE;
    end
  end
  assign grant_sel       = r_grant;
  assign mem_read        = (r_state == SERVE_I) | (r_state == SERVE_D & d_read & ~d_write);
  assign mem_write       = r_state == SERVE_D & d_write;
  assign mem_wdata       = d_wdata;
  assign mem_byte_enable = r_grant == GRANT_D ? d_mbe : '1;
  assign i_rdata         = mem_rdata;
  assign d_rdata         = mem_rdata;
  assign i_resp          = r_state == SERVE_I & mem_resp;
  assign d_resp          = r_state == SERVE_D & mem_resp;
  twomux #(.WIDTH(WIDTH)) u_addr_mux (
    .sel(r_grant),
    .a  (i_address),
    .b  (d_address),
    .y  (mem_address)
  );
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      i_grant_cnt  <= '0;
      d_grant_cnt  <= '0;
      conflict_cnt <= '0;
    end else begin
      i_grant_cnt  <= i_grant_cnt + 32'(w_go_i);
      d_grant_cnt  <= d_grant_cnt + 32'(w_go_d);
      conflict_cnt <= conflict_cnt + 32'(w_idle & w_i_req & w_d_req);
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table, hand sequences and randomized model check for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;
  localparam logic H = 1'b1, L = 1'b0;
  logic        clk, rst;
  logic        i_read, i_resp, d_read, d_write, d_resp, mem_read, mem_write, mem_resp, grant_sel;
  logic [31:0] i_address, i_rdata, d_address, d_wdata, d_rdata, mem_address, mem_wdata, mem_rdata;
  logic [3:0]  d_mbe, mem_byte_enable;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] i_grant_cnt, d_grant_cnt, conflict_cnt;
`endif
  int total = 0, bad = 0;
  mem_port_arbiter #(.WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_mbe(d_mbe), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
`ifdef ARB_PERF_CNT_EN
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt),
`endif
    .grant_sel(grant_sel)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic rst, ir;
    logic [31:0] ia;
    logic dr, dw;
    logic [31:0] da, dwd;
    logic [3:0] dm;
    logic mr;
    logic [31:0] md;
    logic e_rd, e_wr;
    logic [31:0] e_addr;
    logic [3:0] e_mbe;
    logic e_ir, e_dr, e_gs;
  } vec_t;
  vec_t tbl[18];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic r, input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dm,
                       input logic mr, input logic [31:0] md);
    rst = r; i_read = ir; i_address = ia; d_read = dr; d_write = dw; d_address = da;
    d_wdata = dwd; d_mbe = dm; mem_resp = mr; mem_rdata = md;
  endtask
`ifdef ARB_PERF_CNT_EN
  task automatic run_s3();
    drive(L, H, 32'h44, L, H, 32'h80, 32'h1, 4'h3, L, 32'h0); tick();
    tick();
    mem_resp = H; tick();
    d_write = L; tick();
    i_read = L; mem_resp = L; tick();
  endtask
`endif
  initial begin
    int own, nxt, starve, wait_c;
    bit ip, dp, dwr, mr;
    logic [31:0] ia_r, da_r, dwd_r, rd;
    logic [3:0] dm_r;
    drive(H, L, 32'h0, L, L, 32'h0, 32'h0, 4'h0, L, 32'h0);
    tick();
    tbl[0]  = '{H,H,32'h40,L,L,32'h0,32'h0,4'h0,L,32'h0,         L,L,32'h40,4'hF,L,L,L};
    tbl[1]  = '{H,H,32'h40,L,L,32'h0,32'h0,4'h0,L,32'h0,         L,L,32'h40,4'hF,L,L,L};
    tbl[2]  = '{L,H,32'h40,L,L,32'h0,32'h0,4'h0,L,32'h0,         L,L,32'h40,4'hF,L,L,L};
    tbl[3]  = '{L,H,32'h40,L,L,32'h0,32'h0,4'h0,L,32'h0,         H,L,32'h40,4'hF,L,L,L};
    tbl[4]  = '{L,H,32'h40,L,L,32'h0,32'h0,4'h0,L,32'h0,         H,L,32'h40,4'hF,L,L,L};
    tbl[5]  = '{L,H,32'h40,L,L,32'h0,32'h0,4'h0,H,32'hDEADBEEF,  H,L,32'h40,4'hF,H,L,L};
    tbl[6]  = '{L,L,32'h40,L,L,32'h0,32'h0,4'h0,L,32'h0,         L,L,32'h40,4'hF,L,L,L};
    tbl[7]  = '{L,H,32'h44,L,H,32'h80,32'h12345678,4'h3,L,32'h0, L,L,32'h44,4'hF,L,L,L};
    tbl[8]  = '{L,H,32'h44,L,H,32'h80,32'h12345678,4'h3,L,32'h0, L,H,32'h80,4'h3,L,L,H};
    tbl[9]  = '{L,H,32'h44,L,H,32'h80,32'h12345678,4'h3,H,32'h11112222, L,H,32'h80,4'h3,L,H,H};
    tbl[10] = '{L,H,32'h44,L,L,32'h80,32'h12345678,4'h3,L,32'h0, H,L,32'h44,4'hF,L,L,L};
    tbl[11] = '{L,H,32'h44,L,L,32'h80,32'h12345678,4'h3,H,32'hCAFEF00D, H,L,32'h44,4'hF,H,L,L};
    tbl[12] = '{L,L,32'h44,L,L,32'h80,32'h12345678,4'h3,L,32'h0, L,L,32'h44,4'hF,L,L,L};
    tbl[13] = '{L,L,32'h0,H,L,32'h90,32'h0,4'hF,L,32'h0,         L,L,32'h0,4'hF,L,L,L};
    tbl[14] = '{L,L,32'h0,H,L,32'h90,32'h0,4'hF,L,32'h0,         H,L,32'h90,4'hF,L,L,H};
    tbl[15] = '{H,L,32'h0,H,L,32'h90,32'h0,4'hF,L,32'h0,         H,L,32'h90,4'hF,L,L,H};
    tbl[16] = '{L,L,32'h0,L,L,32'h90,32'h0,4'hF,H,32'h55AA55AA,  L,L,32'h0,4'hF,L,L,L};
    tbl[17] = '{L,L,32'h0,L,L,32'h0,32'h0,4'h0,L,32'h0,          L,L,32'h0,4'hF,L,L,L};
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dwd, tbl[i].dm, tbl[i].mr, tbl[i].md);
      #3;
      chk($sformatf("v%0d mem_read", i), 32'(mem_read), 32'(tbl[i].e_rd));
      chk($sformatf("v%0d mem_write", i), 32'(mem_write), 32'(tbl[i].e_wr));
      chk($sformatf("v%0d mem_address", i), mem_address, tbl[i].e_addr);
      chk($sformatf("v%0d mem_byte_enable", i), 32'(mem_byte_enable), 32'(tbl[i].e_mbe));
      chk($sformatf("v%0d i_resp", i), 32'(i_resp), 32'(tbl[i].e_ir));
      chk($sformatf("v%0d d_resp", i), 32'(d_resp), 32'(tbl[i].e_dr));
      chk($sformatf("v%0d grant_sel", i), 32'(grant_sel), 32'(tbl[i].e_gs));
      chk($sformatf("v%0d i_rdata", i), i_rdata, tbl[i].md);
      chk($sformatf("v%0d d_rdata", i), d_rdata, tbl[i].md);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].dwd);
      tick();
    end
    drive(L, H, 32'h100, H, L, 32'h200, 32'h0, 4'h5, L, 32'h0);
    #3;
    chk("alt idle mem_read", 32'(mem_read), 32'd0);
    tick();
    for (int k = 1; k <= 9; k++) begin
      i_read = k <= 8;
      mem_resp = H;
      mem_rdata = 32'(k);
      #3;
      chk($sformatf("alt%0d d_resp", k), 32'(d_resp), 32'(k % 2 == 1));
      chk($sformatf("alt%0d i_resp", k), 32'(i_resp), 32'(k % 2 == 0));
      chk($sformatf("alt%0d grant_sel", k), 32'(grant_sel), 32'(k % 2 == 1));
      chk($sformatf("alt%0d mem_address", k), mem_address, k % 2 == 1 ? 32'h200 : 32'h100);
      tick();
    end
    drive(L, L, 32'h0, L, L, 32'h0, 32'h0, 4'h0, L, 32'h0);
    #3;
    chk("alt end mem_read", 32'(mem_read), 32'd0);
    tick();
`ifdef ARB_PERF_CNT_EN
    rst = H; tick(); rst = L;
    run_s3();
    run_s3();
    #3;
    chk("perf d_grant_cnt", d_grant_cnt, 32'd2);
    chk("perf i_grant_cnt", i_grant_cnt, 32'd2);
    chk("perf conflict_cnt", conflict_cnt, 32'd2);
    tick();
`endif
    rst = H; tick(); rst = L;
    own = 0; starve = 0; wait_c = 0; ip = 0; dp = 0; dwr = 0;
    ia_r = '0; da_r = '0; dwd_r = '0; dm_r = '0;
    for (int c = 0; c < 3000; c++) begin
      mr = own != 0 ? wait_c == 0 : $urandom_range(0, 7) == 0;
      rd = $urandom;
      drive(L, ip, ia_r, dp && !dwr, dp && dwr, da_r, dwd_r, dm_r, mr, rd);
      #3;
      chk($sformatf("rnd%0d mem_read", c), 32'(mem_read), 32'(own == 1 || (own == 2 && !dwr)));
      chk($sformatf("rnd%0d mem_write", c), 32'(mem_write), 32'(own == 2 && dwr));
      chk($sformatf("rnd%0d i_resp", c), 32'(i_resp), 32'(own == 1 && mr));
      chk($sformatf("rnd%0d d_resp", c), 32'(d_resp), 32'(own == 2 && mr));
      chk($sformatf("rnd%0d i_rdata", c), i_rdata, rd);
      if (own != 0) begin
        chk($sformatf("rnd%0d mem_address", c), mem_address, own == 1 ? ia_r : da_r);
        chk($sformatf("rnd%0d mem_byte_enable", c), 32'(mem_byte_enable), own == 1 ? 32'hF : 32'(dm_r));
        chk($sformatf("rnd%0d grant_sel", c), 32'(grant_sel), 32'(own == 2));
      end
      if (own == 0) begin
        if (ip && dp) begin
          if (starve == LIMIT) nxt = 1;
          else begin
            nxt = 2;
            starve++;
          end
        end else nxt = ip ? 1 : dp ? 2 : 0;
      end else if (mr) begin
        nxt = (own == 1 && dp) ? 2 : (own == 2 && ip) ? 1 : 0;
        if (own == 1) ip = 0;
        else dp = 0;
      end else nxt = own;
      if (nxt == 1 && own != 1) starve = 0;
      if (nxt != 0 && nxt != own) wait_c = $urandom_range(0, 3);
      else if (nxt != 0) wait_c--;
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1;
        ia_r = $urandom;
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1;
        dwr = $urandom_range(0, 1) == 1;
        da_r = $urandom;
        dwd_r = $urandom;
        dm_r = 4'($urandom);
      end
      own = nxt;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
